// File: rtl/dmem_responder.sv
// Word-addressed data store answering one load/store at a time after a fixed
// number of wait states; out-of-range or misaligned requests get an error response.
//   state  | meaning
//   S_IDLE | ready for a request
//   S_WAIT | request captured, counting wait states
//   S_RESP | response presented until the initiator takes it
module dmem_responder #(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    input  logic        resp_ready,
    output logic        busy
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [31:0] LIMIT    = 32'(4 * DEPTH);
    localparam logic [3:0]  CNT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH];

    logic          w_accept;
    logic          w_enter_resp;
    logic          w_src_write;
    logic [31:0]   w_src_addr;
    logic [31:0]   w_src_wdata;
    logic          w_err;
    logic [AW-1:0] w_idx;

    assign req_ready  = (r_state == S_IDLE) && !reset;
    assign busy       = (r_state != S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    assign w_accept     = req_valid && req_ready;
    assign w_enter_resp = (r_state != S_RESP) && (w_next == S_RESP);

    // With no wait states RESP is entered on the acceptance edge, so the
    // operands must come straight from the request port in that case.
    assign w_src_write = (r_state == S_IDLE) ? req_write : r_write;
    assign w_src_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_src_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
    assign w_err       = (w_src_addr[1:0] != 2'b00) || (w_src_addr >= LIMIT);
    assign w_idx       = w_src_addr[AW+1:2];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = (WAIT == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
            S_RESP:  if (resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= CNT_LOAD;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) begin
                r_err   <= w_err;
                r_rdata <= (!w_src_write && !w_err) ? r_mem[w_idx] : 32'd0;
            end else if (r_state == S_RESP && resp_ready) begin
                r_err   <= 1'b0;
                r_rdata <= 32'd0;
            end
        end
    end

    // Store contents survive reset; a reset on the entry edge cancels the write.
    always_ff @(posedge clock) begin
        if (!reset && w_enter_resp && w_src_write && !w_err)
            r_mem[w_idx] <= w_src_wdata;
    end

endmodule
